// File: rtl/imm_gen_pkg.sv
// Shared opcode and format constants for the immediate-generation stage.
package imm_gen_pkg;

    typedef logic [2:0] fmt_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam fmt_t FMT_R    = 3'd0;
    localparam fmt_t FMT_I    = 3'd1;
    localparam fmt_t FMT_S    = 3'd2;
    localparam fmt_t FMT_B    = 3'd3;
    localparam fmt_t FMT_U    = 3'd4;
    localparam fmt_t FMT_J    = 3'd5;
    localparam fmt_t FMT_NONE = 3'd7;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: format, sign-extended immediate and pc-relative target.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic [XLEN-1:0] target,
    output logic            illegal
);

    logic [31:0] imm32;

    always_comb begin
        imm32   = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (instr[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM: begin
                imm32 = {{20{instr[31]}}, instr[31:20]};
                fmt   = FMT_I;
            end
            OPC_STORE: begin
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                fmt   = FMT_S;
            end
            OPC_BRANCH: begin
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                fmt   = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32 = {instr[31:12], 12'b0};
                fmt   = FMT_U;
            end
            OPC_JAL: begin
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                fmt   = FMT_J;
            end
            OPC_OP: begin
                fmt = FMT_R;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    // 32-bit immediate already carries instr[31] in its top bit; widen by sign.
    assign imm    = XLEN'($signed(imm32));
    assign target = pc + imm;

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage: decode, one output register plus one skid entry.
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [XLEN-1:0]  pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [XLEN-1:0]  out_target,
    output logic             out_illegal,
    output logic [CNT_W-1:0] ill_cnt
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [2:0]      fmt;
        logic            illegal;
    } beat_t;

    beat_t dec_beat;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr   (instr),
        .pc      (pc),
        .imm     (dec_beat.imm),
        .fmt     (dec_beat.fmt),
        .target  (dec_beat.target),
        .illegal (dec_beat.illegal)
    );

    beat_t            out_q, out_d, skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_full_q, skid_full_d;
    logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
    logic             accept, drain;

    assign accept = in_valid && !skid_full_q;
    assign drain  = out_valid_q && out_ready;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        ill_cnt_d   = ill_cnt_q;

        if (drain || !out_valid_q) begin
            // A full skid blocks accept, so it is the only candidate here.
            if (skid_full_q) begin
                out_d       = skid_q;
                out_valid_d = 1'b1;
                skid_full_d = 1'b0;
            end else if (accept) begin
                out_d       = dec_beat;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d      = dec_beat;
            skid_full_d = 1'b1;
        end

        if (drain && out_q.illegal && (ill_cnt_q != {CNT_W{1'b1}})) begin
            ill_cnt_d = ill_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            skid_q      <= '0;
            skid_full_q <= 1'b0;
            ill_cnt_q   <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
            ill_cnt_q   <= ill_cnt_d;
        end
    end

    assign in_ready    = !skid_full_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_target  = out_q.target;
    assign out_illegal = out_q.illegal;
    assign ill_cnt     = ill_cnt_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: 32-bit (2-bit counter) and 64-bit instances against a queue model.
module tb_imm_gen_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [31:0] pc32;
    logic [63:0] pc64;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] imm32, tgt32;
    logic [2:0]  fmt32;
    logic [1:0]  cnt32;

    logic        in_ready64, out_valid64, ill64;
    logic [63:0] imm64, tgt64;
    logic [2:0]  fmt64;
    logic [15:0] cnt64;

    imm_gen_stage #(
        .XLEN  (32),
        .CNT_W (2)
    ) dut32 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready32),
        .instr       (instr),
        .pc          (pc32),
        .out_valid   (out_valid32),
        .out_ready   (out_ready),
        .out_imm     (imm32),
        .out_fmt     (fmt32),
        .out_target  (tgt32),
        .out_illegal (ill32),
        .ill_cnt     (cnt32)
    );

    imm_gen_stage #(
        .XLEN  (64),
        .CNT_W (16)
    ) dut64 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready64),
        .instr       (instr),
        .pc          (pc64),
        .out_valid   (out_valid64),
        .out_ready   (out_ready),
        .out_imm     (imm64),
        .out_fmt     (fmt64),
        .out_target  (tgt64),
        .out_illegal (ill64),
        .ill_cnt     (cnt64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] imm32;
        logic [31:0] tgt32;
        logic [63:0] imm64;
        logic [63:0] tgt64;
        logic [2:0]  fmt;
        logic        ill;
    } beat_t;

    beat_t q[$];
    int    m_cnt32, m_cnt64;
    bit    zero_exp;
    int    n_assert, n_fail;

    function automatic longint fld(input logic [31:0] i, input int lo, input int w);
        logic [31:0] mask;
        mask = (32'h1 << w) - 32'h1;
        return longint'((i >> lo) & mask);
    endfunction

    // Immediate values built arithmetically from the instruction fields.
    function automatic longint ref_imm(input logic [31:0] i, output logic [2:0] f,
                                       output logic il);
        int     si;
        longint s;
        si = i;
        s  = si;
        f  = 3'd7;
        il = 1'b0;
        case (i[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: begin f = 3'd1; return s >>> 20; end
            7'h23: begin f = 3'd2; return (s >>> 25) * 32 + fld(i, 7, 5); end
            7'h63: begin
                f = 3'd3;
                return (s >>> 31) * 4096 + fld(i, 7, 1) * 2048 + fld(i, 25, 6) * 32
                       + fld(i, 8, 4) * 2;
            end
            7'h37, 7'h17: begin f = 3'd4; return (s >>> 12) * 4096; end
            7'h6f: begin
                f = 3'd5;
                return (s >>> 31) * 1048576 + fld(i, 12, 8) * 4096 + fld(i, 20, 1) * 2048
                       + fld(i, 21, 10) * 2;
            end
            7'h33: begin f = 3'd0; return 0; end
            default: begin il = 1'b1; return 0; end
        endcase
    endfunction

    function automatic beat_t mk_beat(input logic [31:0] i, input logic [31:0] p32,
                                      input logic [63:0] p64);
        beat_t       b;
        longint      v;
        logic [63:0] vb;
        v       = ref_imm(i, b.fmt, b.ill);
        vb      = v;
        b.imm64 = vb;
        b.imm32 = vb[31:0];
        b.tgt32 = p32 + vb[31:0];
        b.tgt64 = p64 + vb;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("in_ready32", 64'(in_ready32), 64'(q.size() < 2));
        chk("in_ready64", 64'(in_ready64), 64'(q.size() < 2));
        chk("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
        chk("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
        chk("ill_cnt32", 64'(cnt32), 64'(m_cnt32));
        chk("ill_cnt64", 64'(cnt64), 64'(m_cnt64));
        if (q.size() > 0) begin
            chk("imm32", 64'(imm32), 64'(q[0].imm32));
            chk("tgt32", 64'(tgt32), 64'(q[0].tgt32));
            chk("fmt32", 64'(fmt32), 64'(q[0].fmt));
            chk("ill32", 64'(ill32), 64'(q[0].ill));
            chk("imm64", imm64, q[0].imm64);
            chk("tgt64", tgt64, q[0].tgt64);
            chk("fmt64", 64'(fmt64), 64'(q[0].fmt));
            chk("ill64", 64'(ill64), 64'(q[0].ill));
        end else if (zero_exp) begin
            chk("zero32", {imm32, tgt32}, 64'h0);
            chk("zero32b", 64'({fmt32, ill32}), 64'h0);
            chk("zero64", imm64 | tgt64, 64'h0);
            chk("zero64b", 64'({fmt64, ill64}), 64'h0);
        end
    endtask

    // Check current outputs, then advance one edge and update the model.
    task automatic cycle();
        bit fo, fi;
        compare_all();
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_cnt32  = 0;
            m_cnt64  = 0;
            zero_exp = 1'b1;
        end else begin
            fo = (q.size() > 0) && out_ready;
            fi = in_valid && (q.size() < 2);
            if (fo) begin
                if (q[0].ill) begin
                    if (m_cnt32 < 3) m_cnt32++;
                    if (m_cnt64 < 65535) m_cnt64++;
                end
                void'(q.pop_front());
            end
            if (fi) begin
                q.push_back(mk_beat(instr, pc32, pc64));
                zero_exp = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] i, input logic [31:0] p32, input logic [63:0] p64);
        in_valid = 1'b1;
        instr    = i;
        pc32     = p32;
        pc64     = p64;
        cycle();
    endtask

    logic [6:0] opc_tab [10];
    int         exp_cnt [6];

    initial begin
        opc_tab = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33};
        exp_cnt = '{0, 1, 2, 3, 3, 3};
        n_assert  = 0;
        n_fail    = 0;
        m_cnt32   = 0;
        m_cnt64   = 0;
        zero_exp  = 1'b1;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        instr     = '0;
        pc32      = '0;
        pc64      = '0;
        @(negedge clk);
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();

        // Back-to-back directed beats, out_ready held high.
        send(32'h03052283, 32'h100, 64'h100);
        chk("d_lw_imm", 64'(imm32), 64'h30);
        chk("d_lw_fmt", 64'(fmt32), 64'd1);
        send(32'h00552023, 32'h100, 64'h100);
        chk("d_sw_imm", 64'(imm32), 64'h0);
        chk("d_sw_fmt", 64'(fmt32), 64'd2);
        send(32'h80230293, 32'h100, 64'h100);
        chk("d_neg_imm32", 64'(imm32), 64'hFFFFF802);
        chk("d_neg_imm64", imm64, 64'hFFFFFFFFFFFFF802);
        send(32'hFF848FE3, 32'h100, 64'h0);
        chk("d_b_imm", 64'(imm32), 64'hFFFFFFFE);
        chk("d_b_tgt", 64'(tgt32), 64'hFE);
        chk("d_b_fmt", 64'(fmt32), 64'd3);
        chk("d_b_wrap64", tgt64, 64'hFFFFFFFFFFFFFFFE);
        send(32'h0080006F, 32'h200, 64'h200);
        chk("d_j_imm", 64'(imm32), 64'h8);
        chk("d_j_tgt", 64'(tgt32), 64'h208);
        chk("d_j_fmt", 64'(fmt32), 64'd5);
        send(32'h123452B7, 32'h100, 64'h100);
        chk("d_u_imm", 64'(imm32), 64'h12345000);
        chk("d_u_fmt", 64'(fmt32), 64'd4);
        in_valid = 1'b0;
        cycle();

        // Backpressure: A to output, B to skid, C held off.
        out_ready = 1'b0;
        send(32'h00100013, 32'h40, 64'h40);
        send(32'h00200013, 32'h40, 64'h40);
        chk("bp_ready_low", 64'(in_ready32), 64'h0);
        chk("bp_hold_a", 64'(imm32), 64'h1);
        send(32'h00300013, 32'h40, 64'h40);
        send(32'h00300013, 32'h40, 64'h40);
        chk("bp_still_a", 64'(imm32), 64'h1);
        out_ready = 1'b1;
        cycle();
        chk("bp_b", 64'(imm32), 64'h2);
        chk("bp_ready_back", 64'(in_ready32), 64'h1);
        cycle();
        chk("bp_c", 64'(imm32), 64'h3);
        in_valid = 1'b0;
        cycle();
        chk("bp_empty", 64'(out_valid32), 64'h0);

        // Illegal opcode with counter saturation on the 2-bit instance.
        for (int k = 0; k < 5; k++) begin
            send(32'h0, 32'h80, 64'h80);
            chk("il_flag", 64'(ill32), 64'h1);
            chk("il_fmt", 64'(fmt32), 64'd7);
            chk("il_imm", 64'(imm32), 64'h0);
            chk("il_cnt", 64'(cnt32), 64'(exp_cnt[k]));
        end
        in_valid = 1'b0;
        cycle();
        chk("il_cnt_sat", 64'(cnt32), 64'(exp_cnt[5]));
        chk("il_cnt64", 64'(cnt64), 64'd5);

        // Reset mid-operation with the skid full and count at 2.
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        send(32'h0, 32'h0, 64'h0);
        send(32'h0, 32'h0, 64'h0);
        in_valid = 1'b0;
        cycle();
        out_ready = 1'b0;
        send(32'h00100013, 32'h10, 64'h10);
        send(32'h00200013, 32'h10, 64'h10);
        chk("rs_pre_ready", 64'(in_ready32), 64'h0);
        chk("rs_pre_cnt", 64'(cnt32), 64'd2);
        rst_n = 1'b0;
        send(32'h00300013, 32'h10, 64'h10);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        chk("rs_valid", 64'(out_valid32), 64'h0);
        chk("rs_ready", 64'(in_ready32), 64'h1);
        chk("rs_cnt", 64'(cnt32), 64'h0);
        chk("rs_data", {imm32, tgt32}, 64'h0);
        out_ready = 1'b1;
        send(32'h123452B7, 32'h10, 64'h10);
        in_valid = 1'b0;
        chk("rs_next", 64'(imm32), 64'h12345000);
        cycle();
        chk("rs_alone", 64'(out_valid32), 64'h0);

        // Randomized traffic with occasional reset.
        for (int n = 0; n < 500; n++) begin
            logic [31:0] r;
            int          idx;
            r   = $urandom;
            idx = $urandom_range(0, 11);
            if (idx < 10) r[6:0] = opc_tab[idx];
            rst_n     = ($urandom_range(0, 99) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            instr     = r;
            pc32      = $urandom;
            pc64      = {$urandom, $urandom};
            cycle();
        end
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
